gcd_stein_unit: RTL and testbench

Parametrised GCD engine that supersedes the fixed 16-bit subtractive GCD. It computes gcd(|x|, |y|) with the binary (Stein) algorithm and performs one reduction step per clock. Inputs can be signed or unsigned, and both sides use valid/ready handshakes, so the block drops directly into streaming arithmetic pipelines. It also reports the number of iterations it took, which the verification bench uses for checks.

---
 rtl/gcd_pkg.sv | 33 +++
 rtl/gcd_stein_step.sv | 52 +++++
 rtl/gcd_stein_unit.sv | 109 ++++++++++
 tb/tb_gcd_stein_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the binary (Stein) GCD engine.
//   gcd_state_t  : controller states
//   step_width() : width of the step counter for a given operand width
//   gcd_model()  : Euclidean reference GCD over 64-bit values; not used by the hardware
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } gcd_state_t;

   // The worst case is about 4*w+1 CALC cycles, so the counter must hold that value.
   function automatic int step_width(input int w);
      return $clog2(4 * w + 2);
   endfunction

   // Callers pass values that are already sign- or zero-extended to 64 bits.
   function automatic longint gcd_model(input longint x, input longint y, input bit signed_mode);
      longint a;
      longint b;
      longint t;
      a = (signed_mode && x < 0) ? -x : x;
      b = (signed_mode && y < 0) ? -y : y;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One binary-GCD reduction step, purely combinational.
//   a, b           : current reduced operands
//   k              : count of common factors of two removed so far
//   a_next, b_next : operands after this step
//   k_next         : common-factor count after this step
//   done           : one operand is zero, so result is final
//   result         : the surviving operand shifted back up by k
module gcd_stein_step
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned K_W   = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [K_W-1:0]   k,
   output logic [WIDTH-1:0] a_next,
   output logic [WIDTH-1:0] b_next,
   output logic [K_W-1:0]   k_next,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      a_next = a;
      b_next = b;
      k_next = k;
      done   = 1'b0;
      result = '0;
      if (a == '0) begin
         done   = 1'b1;
         result = b << k;
      end else if (b == '0) begin
         done   = 1'b1;
         result = a << k;
      end else if (!a[0] && !b[0]) begin
         // A shared factor of two is set aside and restored by the final shift.
         a_next = a >> 1;
         b_next = b >> 1;
         k_next = k + 1'b1;
      end else if (!a[0]) begin
         a_next = a >> 1;
      end else if (!b[0]) begin
         b_next = b >> 1;
      end else if (a >= b) begin
         a_next = a - b;
      end else begin
         b_next = b - a;
      end
   end

endmodule

// File: rtl/gcd_stein_unit.sv
// Streaming binary (Stein) GCD engine, one reduction step per clock.
//   clk, rst             : clock and synchronous active-high reset
//   in_valid, in_ready   : operand handshake; the block is ready only in IDLE
//   x_in, y_in           : operands, two's complement when SIGNED=1
//   out_valid, out_ready : result handshake; the result is held until it is accepted
//   gcd_out              : gcd(|x|, |y|), unsigned
//   steps_out            : CALC cycles used, which equals the latency from acceptance
module gcd_stein_unit
   import gcd_pkg::*;
#(
   parameter int unsigned  WIDTH  = 16,
   parameter bit           SIGNED = 1'b1,
   localparam int unsigned STEP_W = step_width(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  x_in,
   input  logic [WIDTH-1:0]  y_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  gcd_out,
   output logic [STEP_W-1:0] steps_out
);

   // The shared factor count k never exceeds WIDTH-1.
   localparam int unsigned K_W = $clog2(WIDTH);

   gcd_state_t        state;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [K_W-1:0]    k;
   logic [STEP_W-1:0] steps;

   logic [WIDTH-1:0]  a_next;
   logic [WIDTH-1:0]  b_next;
   logic [K_W-1:0]    k_next;
   logic              st_done;
   logic [WIDTH-1:0]  st_result;

   // The most negative input maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return (SIGNED && v[WIDTH-1]) ? -v : v;
   endfunction

   // Gated by rst so that the block never advertises readiness while a reset is applied.
   assign in_ready = (state == IDLE) && !rst;

   gcd_stein_step #(
      .WIDTH (WIDTH),
      .K_W   (K_W)
   ) u_step (
      .a      (a),
      .b      (b),
      .k      (k),
      .a_next (a_next),
      .b_next (b_next),
      .k_next (k_next),
      .done   (st_done),
      .result (st_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         gcd_out   <= '0;
         steps_out <= '0;
         a         <= '0;
         b         <= '0;
         k         <= '0;
         steps     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a     <= mag(x_in);
                  b     <= mag(y_in);
                  k     <= '0;
                  steps <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               steps <= steps + 1'b1;
               if (st_done) begin
                  gcd_out   <= st_result;
                  steps_out <= steps + 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  a <= a_next;
                  b <= b_next;
                  k <= k_next;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_stein_unit.sv
// Self-checking bench for gcd_stein_unit: a directed vector table, hand-written
// handshake and reset sequences, and a short random sweep at WIDTH 8 and 32.
`timescale 1ns/1ps
module tb_gcd_stein_unit;
   import gcd_pkg::*;

   localparam int unsigned SW16   = step_width(16);
   localparam int          NSWEEP = 400;  // kept short to bound run time at WIDTH=32

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_g = 1'b1;
   logic rst_u = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   sweeps_left = 4;

   // Signed 16-bit instance
   logic             s_iv, s_or, s_rdy, s_ov;
   logic [15:0]      s_x, s_y, s_g;
   logic [SW16-1:0]  s_st;
   // Unsigned 16-bit instance
   logic             u_iv, u_or, u_rdy, u_ov;
   logic [15:0]      u_x, u_y, u_g;
   logic [SW16-1:0]  u_st;

   gcd_stein_unit #(.WIDTH(16), .SIGNED(1'b1)) dut (
      .clk(clk), .rst(rst_g), .in_valid(s_iv), .in_ready(s_rdy), .x_in(s_x), .y_in(s_y),
      .out_valid(s_ov), .out_ready(s_or), .gcd_out(s_g), .steps_out(s_st)
   );

   gcd_stein_unit #(.WIDTH(16), .SIGNED(1'b0)) dut_u (
      .clk(clk), .rst(rst_u), .in_valid(u_iv), .in_ready(u_rdy), .x_in(u_x), .y_in(u_y),
      .out_valid(u_ov), .out_ready(u_or), .gcd_out(u_g), .steps_out(u_st)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Presents one operand pair and waits for out_valid; lat counts edges after acceptance.
   task automatic run_op(input bit uns, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] g, output int st, output int lat, output bit ok);
      bit seen;
      ok   = 1'b0;
      lat  = 0;
      g    = '0;
      st   = 0;
      seen = 1'b0;
      @(negedge clk);
      if (uns) begin u_iv = 1'b1; u_x = x; u_y = y; end
      else     begin s_iv = 1'b1; s_x = x; s_y = y; end
      for (int i = 0; i < 50 && !seen; i++) begin
         if (uns ? u_rdy : s_rdy) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         u_iv = 1'b0;
         s_iv = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      u_iv = 1'b0;
      s_iv = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk);
         lat++;
         #1;
         if (uns ? u_ov : s_ov) ok = 1'b1;
      end
      g  = uns ? u_g : s_g;
      st = int'(uns ? u_st : s_st);
   endtask

   typedef struct {
      bit          uns;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] g;
      int          st;
      string       name;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [15:0] g;
      int          st;
      int          lat;
      bit          ok;

      vecs[0]  = '{1'b0, 16'd12,   16'd18,   16'd6,      6, "12_18"};
      vecs[1]  = '{1'b0, 16'hFFF4, 16'd18,   16'd6,      6, "m12_18"};
      vecs[2]  = '{1'b0, 16'hFFF4, 16'hFFEE, 16'd6,      6, "m12_m18"};
      vecs[3]  = '{1'b0, 16'h8000, 16'd0,    16'h8000,   1, "min_0"};
      vecs[4]  = '{1'b1, 16'h8000, 16'h0C00, 16'h0400,  19, "u8000_0c00"};
      vecs[5]  = '{1'b0, 16'd0,    16'd0,    16'd0,      1, "0_0"};
      vecs[6]  = '{1'b0, 16'd0,    16'd7,    16'd7,      1, "0_7"};
      vecs[7]  = '{1'b0, 16'd9,    16'd0,    16'd9,      1, "9_0"};
      vecs[8]  = '{1'b0, 16'd1,    16'd1,    16'd1,      2, "1_1"};
      vecs[9]  = '{1'b0, 16'd10,   16'd4,    16'd2,      7, "10_4"};
      vecs[10] = '{1'b0, 16'd48,   16'd36,   16'd12,     8, "48_36"};

      s_iv = 1'b0; s_x = '0; s_y = '0; s_or = 1'b1;
      u_iv = 1'b0; u_x = '0; u_y = '0; u_or = 1'b1;

      // Reset values while rst is still applied
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset in_ready", s_rdy, 0);
      chk("reset out_valid", s_ov, 0);
      chk("reset gcd_out", s_g, 0);
      chk("reset steps_out", s_st, 0);
      rst_g = 1'b0;
      rst_u = 1'b0;
      @(negedge clk);
      chk("idle in_ready", s_rdy, 1);
      chk("idle in_ready unsigned", u_rdy, 1);

      foreach (vecs[i]) begin
         run_op(vecs[i].uns, vecs[i].x, vecs[i].y, g, st, lat, ok);
         chk({vecs[i].name, " completed"}, ok, 1);
         chk({vecs[i].name, " gcd"}, g, vecs[i].g);
         chk({vecs[i].name, " steps"}, st, vecs[i].st);
         chk({vecs[i].name, " latency"}, lat, st);
      end

      // Accepting a result frees the block for the very next cycle
      run_op(1'b0, 16'd12, 16'd18, g, st, lat, ok);
      chk("basic gcd", g, 6);
      @(posedge clk);
      #1;
      chk("ready after accept", s_rdy, 1);
      chk("valid cleared after accept", s_ov, 0);

      // Backpressure: the result holds and a new request is ignored
      s_or = 1'b0;
      run_op(1'b0, 16'd48, 16'd36, g, st, lat, ok);
      chk("bp gcd", g, 12);
      @(negedge clk);
      s_iv = 1'b1; s_x = 16'd5; s_y = 16'd5;
      for (int i = 0; i < 10; i++) begin
         chk("bp out_valid", s_ov, 1);
         chk("bp gcd held", s_g, 12);
         chk("bp in_ready", s_rdy, 0);
         @(negedge clk);
      end
      s_iv = 1'b0;
      s_or = 1'b1;
      @(posedge clk);
      #1;
      chk("bp released out_valid", s_ov, 0);
      chk("bp released in_ready", s_rdy, 1);

      // Reset in the middle of a long computation discards it
      @(negedge clk);
      u_iv = 1'b1; u_x = 16'hFFFF; u_y = 16'd1;
      @(posedge clk);
      #1;
      u_iv = 1'b0;
      chk("rm accepted", u_rdy, 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rm still calculating", u_ov, 0);
      rst_u = 1'b1;
      @(posedge clk);
      #1;
      rst_u = 1'b0;
      @(negedge clk);
      chk("rm out_valid", u_ov, 0);
      chk("rm gcd_out", u_g, 0);
      chk("rm steps_out", u_st, 0);
      chk("rm in_ready", u_rdy, 1);
      run_op(1'b1, 16'd10, 16'd4, g, st, lat, ok);
      chk("after rm gcd", g, 2);
      chk("after rm steps", st, 7);

      // Reset wins over a simultaneous request
      @(negedge clk);
      rst_u = 1'b1;
      u_iv = 1'b1; u_x = 16'd3; u_y = 16'd6;
      @(posedge clk);
      #1;
      rst_u = 1'b0;
      u_iv = 1'b0;
      @(negedge clk);
      chk("rst beats in_valid", u_rdy, 1);
      repeat (3) @(negedge clk);
      chk("rst beats in_valid no result", u_ov, 0);

      for (int i = 0; i < 90000 && sweeps_left > 0; i++) @(negedge clk);
      chk("sweeps completed", sweeps_left, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_sw
      localparam int unsigned W   = (gi < 2) ? 8 : 32;
      localparam bit          S   = (gi % 2) == 1;
      localparam int unsigned SWW = step_width(W);

      logic           iv, ord, rdy, ov;
      logic [W-1:0]   x, y, g;
      logic [SWW-1:0] st;

      gcd_stein_unit #(.WIDTH(W), .SIGNED(S)) u_sw (
         .clk(clk), .rst(rst_g), .in_valid(iv), .in_ready(rdy), .x_in(x), .y_in(y),
         .out_valid(ov), .out_ready(ord), .gcd_out(g), .steps_out(st)
      );

      initial begin : sweep
         longint xe;
         longint ye;
         bit     got;
         iv = 1'b0; ord = 1'b1; x = '0; y = '0;
         wait (rst_g == 1'b0);
         for (int n = 0; n < NSWEEP; n++) begin
            @(negedge clk);
            x = W'($urandom);
            y = W'($urandom);
            if (n == 0) begin x = {1'b1, {(W-1){1'b0}}}; y = '0; end
            if (n == 1) begin x = '1; y = '1; end
            if (n == 2) begin x = {1'b1, {(W-1){1'b0}}}; y = {1'b1, {(W-1){1'b0}}}; end
            if (n % 5 == 3) y = W'(x * 3);
            iv  = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
               if (rdy) got = 1'b1;
               else @(negedge clk);
            end
            @(posedge clk);
            #1;
            iv  = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 4 * W + 8 && !got; i++) begin
               @(posedge clk);
               #1;
               if (ov) got = 1'b1;
            end
            xe = S ? longint'($signed(x)) : longint'(x);
            ye = S ? longint'($signed(y)) : longint'(y);
            chk($sformatf("sweep W%0d S%0d x=%0h y=%0h done", W, S, x, y), got, 1);
            chk($sformatf("sweep W%0d S%0d x=%0h y=%0h gcd", W, S, x, y), 64'(g),
                gcd_model(xe, ye, S));
            chk($sformatf("sweep W%0d S%0d x=%0h y=%0h steps bound", W, S, x, y),
                64'(int'(st) <= 4 * W + 1), 1);
         end
         sweeps_left--;
      end
   end

endmodule
